// File: rtl/sd_spi_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_spi_responder_if
// Purpose  : SPI link and external block-memory port of the SD SPI responder.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_spi_responder_if;
   logic        SCLK;
   logic        MOSI;
   logic        CS;
   logic        MISO;
   logic [31:0] MEM_BLK;
   logic [8:0]  MEM_IDX;
   logic        MEM_RD_STB;
   logic [7:0]  MEM_RD_DATA;
   logic        MEM_WR_STB;
   logic [7:0]  MEM_WR_DATA;
   logic        IDLE_FLAG;

   modport slave (
      input  SCLK, MOSI, CS, MEM_RD_DATA,
      output MISO, MEM_BLK, MEM_IDX, MEM_RD_STB, MEM_WR_STB, MEM_WR_DATA, IDLE_FLAG
   );

   modport master (
      output SCLK, MOSI, CS, MEM_RD_DATA,
      input  MISO, MEM_BLK, MEM_IDX, MEM_RD_STB, MEM_WR_STB, MEM_WR_DATA, IDLE_FLAG
   );
endinterface
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_spi_responder
// Purpose  : SD-card SPI-mode card model: command decode, R1/R3/R7 replies,
//            single-block read/write against an external byte memory.
// Revision : 1.0 - initial release
// ============================================================================
module sd_spi_responder #(
   parameter int NCR_BYTES    = 1,
   parameter int INIT_RETRIES = 2,
   parameter int READ_GAP     = 2,
   parameter int BUSY_BYTES   = 4
) (
   input  logic              CLOCK50,
   input  logic              RESET,
   sd_spi_responder_if.slave bus
);
   localparam logic [7:0] RETRY_LIM = 8'(INIT_RETRIES);
   localparam logic [9:0] NCR_LAST  = 10'(NCR_BYTES - 1);
   localparam logic [9:0] GAP_LAST  = 10'(READ_GAP - 1);
   localparam logic [9:0] BUSY_LAST = 10'(BUSY_BYTES - 1);
   localparam logic [1:0] MODE_NONE = 2'd0;
   localparam logic [1:0] MODE_RD   = 2'd1;
   localparam logic [1:0] MODE_WR   = 2'd2;

   typedef enum logic [3:0] {
      WAIT_CMD, RX_CMD, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
      WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
   } state_t;

   state_t      state_q;
   logic [1:0]  sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic        sclk_prev_q;
   logic [2:0]  bit_cnt_q;
   logic [6:0]  rx_shift_q;
   logic [7:0]  tx_shift_q, tx_next_q;
   logic        load_pend_q;
   logic [5:0]  cmd_q;
   logic [31:0] arg_q;
   logic [9:0]  cnt_q;
   logic [39:0] resp_q;
   logic [2:0]  resp_left_q;
   logic [1:0]  mode_q;
   logic        idle_q, app_q;
   logic [7:0]  retry_q;
   logic        rd_req_q, rd_cap_q;
   logic [7:0]  rd_byte_q;
   logic [31:0] blk_q;
   logic [8:0]  idx_q;
   logic        rd_stb_q, wr_stb_q;
   logic [7:0]  wr_data_q;

   logic        w_cs, w_mosi, w_rise, w_fall, w_byte_done;
   logic [7:0]  w_rx_byte;
   logic [39:0] w_resp;
   logic [2:0]  w_resp_len;
   logic [1:0]  w_mode;

   assign w_cs        = cs_sync_q[1];
   assign w_mosi      = mosi_sync_q[1];
   assign w_rise      = sclk_sync_q[1] & ~sclk_prev_q;
   assign w_fall      = ~sclk_sync_q[1] & sclk_prev_q;
   assign w_byte_done = w_rise & (bit_cnt_q == 3'd7) & ~w_cs;
   assign w_rx_byte   = {rx_shift_q, w_mosi};

   // Response for the command whose CRC byte is completing; R1 is the MSB byte.
   always_comb begin
      w_resp     = {5'b0, 1'b1, 1'b0, idle_q, 32'h0};
      w_resp_len = 3'd1;
      w_mode     = MODE_NONE;
      case (cmd_q)
         6'd0:  w_resp[39:32] = 8'h01;
         6'd8:  begin
            w_resp     = {7'b0, idle_q, 8'h00, 8'h00, 4'h0, arg_q[11:8], arg_q[7:0]};
            w_resp_len = 3'd5;
         end
         6'd55: w_resp[39:32] = {7'b0, idle_q};
         6'd41: if (app_q) w_resp[39:32] = (retry_q < RETRY_LIM) ? 8'h01 : 8'h00;
         6'd58: begin
            w_resp     = {7'b0, idle_q, 8'hC0, 8'hFF, 8'h80, 8'h00};
            w_resp_len = 3'd5;
         end
         6'd17, 6'd24: begin
            if (idle_q) begin
               w_resp[39:32] = 8'h05;
            end else begin
               w_resp[39:32] = 8'h00;
               w_mode        = (cmd_q == 6'd17) ? MODE_RD : MODE_WR;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK50 or negedge RESET) begin
      if (!RESET) begin
         state_q     <= WAIT_CMD;
         sclk_sync_q <= 2'b00;
         mosi_sync_q <= 2'b11;
         cs_sync_q   <= 2'b11;
         sclk_prev_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'h00;
         tx_shift_q  <= 8'hFF;
         tx_next_q   <= 8'hFF;
         load_pend_q <= 1'b0;
         cmd_q       <= 6'd0;
         arg_q       <= 32'h0;
         cnt_q       <= 10'd0;
         resp_q      <= 40'h0;
         resp_left_q <= 3'd0;
         mode_q      <= MODE_NONE;
         idle_q      <= 1'b1;
         app_q       <= 1'b0;
         retry_q     <= 8'd0;
         rd_req_q    <= 1'b0;
         rd_cap_q    <= 1'b0;
         rd_byte_q   <= 8'h00;
         blk_q       <= 32'h0;
         idx_q       <= 9'd0;
         rd_stb_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_data_q   <= 8'h00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], bus.SCLK};
         mosi_sync_q <= {mosi_sync_q[0], bus.MOSI};
         cs_sync_q   <= {cs_sync_q[0], bus.CS};
         sclk_prev_q <= sclk_sync_q[1];
         rd_stb_q    <= 1'b0;
         wr_stb_q    <= 1'b0;
         rd_cap_q    <= rd_stb_q;
         if (rd_cap_q) rd_byte_q <= bus.MEM_RD_DATA;

         if (w_cs) begin
            state_q     <= WAIT_CMD;
            bit_cnt_q   <= 3'd0;
            tx_shift_q  <= 8'hFF;
            load_pend_q <= 1'b0;
            rd_req_q    <= 1'b0;
         end else begin
            if (w_fall) begin
               if (load_pend_q) begin
                  tx_shift_q  <= tx_next_q;
                  load_pend_q <= 1'b0;
                  // Memory fetch is launched as the preceding byte goes out.
                  if (rd_req_q) begin
                     rd_stb_q <= 1'b1;
                     rd_req_q <= 1'b0;
                  end
               end else begin
                  tx_shift_q <= {tx_shift_q[6:0], 1'b1};
               end
            end
            if (w_rise) begin
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               rx_shift_q <= {rx_shift_q[5:0], w_mosi};
            end
            if (w_byte_done) begin
               load_pend_q <= 1'b1;
               tx_next_q   <= 8'hFF;
               case (state_q)
                  WAIT_CMD: begin
                     if (w_rx_byte[7:6] == 2'b01) begin
                        cmd_q   <= w_rx_byte[5:0];
                        cnt_q   <= 10'd0;
                        state_q <= RX_CMD;
                     end
                  end
                  RX_CMD: begin
                     if (cnt_q == 10'd4) begin
                        resp_q      <= w_resp;
                        resp_left_q <= w_resp_len;
                        mode_q      <= w_mode;
                        cnt_q       <= NCR_LAST;
                        state_q     <= RESP;
                        app_q       <= (cmd_q == 6'd55);
                        if (w_mode != MODE_NONE) blk_q <= arg_q;
                        if (cmd_q == 6'd0) begin
                           idle_q  <= 1'b1;
                           retry_q <= 8'd0;
                        end
                        if (cmd_q == 6'd41 && app_q) begin
                           if (retry_q < RETRY_LIM) retry_q <= retry_q + 8'd1;
                           else                     idle_q  <= 1'b0;
                        end
                     end else begin
                        arg_q <= {arg_q[23:0], w_rx_byte};
                        cnt_q <= cnt_q + 10'd1;
                     end
                  end
                  RESP: begin
                     if (cnt_q != 10'd0) begin
                        cnt_q <= cnt_q - 10'd1;
                     end else if (resp_left_q != 3'd0) begin
                        tx_next_q   <= resp_q[39:32];
                        resp_q      <= {resp_q[31:0], 8'h00};
                        resp_left_q <= resp_left_q - 3'd1;
                     end else if (mode_q == MODE_RD) begin
                        if (READ_GAP == 0) begin
                           tx_next_q <= 8'hFE;
                           idx_q     <= 9'd0;
                           rd_req_q  <= 1'b1;
                           state_q   <= RD_TOKEN;
                        end else begin
                           cnt_q   <= GAP_LAST;
                           state_q <= RD_GAP;
                        end
                     end else if (mode_q == MODE_WR) begin
                        state_q <= WR_TOKEN;
                     end else begin
                        state_q <= WAIT_CMD;
                     end
                  end
                  RD_GAP: begin
                     if (cnt_q != 10'd0) begin
                        cnt_q <= cnt_q - 10'd1;
                     end else begin
                        tx_next_q <= 8'hFE;
                        idx_q     <= 9'd0;
                        rd_req_q  <= 1'b1;
                        state_q   <= RD_TOKEN;
                     end
                  end
                  RD_TOKEN: begin
                     tx_next_q <= rd_byte_q;
                     idx_q     <= 9'd1;
                     rd_req_q  <= 1'b1;
                     cnt_q     <= 10'd0;
                     state_q   <= RD_DATA;
                  end
                  RD_DATA: begin
                     if (cnt_q == 10'd511) begin
                        cnt_q   <= 10'd0;
                        state_q <= RD_CRC;
                     end else begin
                        tx_next_q <= rd_byte_q;
                        cnt_q     <= cnt_q + 10'd1;
                        if (cnt_q != 10'd510) begin
                           idx_q    <= cnt_q[8:0] + 9'd2;
                           rd_req_q <= 1'b1;
                        end
                     end
                  end
                  RD_CRC: begin
                     if (cnt_q == 10'd0) cnt_q   <= 10'd1;
                     else                state_q <= WAIT_CMD;
                  end
                  WR_TOKEN: begin
                     if (w_rx_byte == 8'hFE) begin
                        cnt_q   <= 10'd0;
                        state_q <= WR_DATA;
                     end
                  end
                  WR_DATA: begin
                     wr_stb_q  <= 1'b1;
                     wr_data_q <= w_rx_byte;
                     idx_q     <= cnt_q[8:0];
                     if (cnt_q == 10'd511) begin
                        cnt_q   <= 10'd0;
                        state_q <= WR_CRC;
                     end else begin
                        cnt_q <= cnt_q + 10'd1;
                     end
                  end
                  WR_CRC: begin
                     if (cnt_q == 10'd0) begin
                        cnt_q <= 10'd1;
                     end else begin
                        tx_next_q <= 8'h05;
                        state_q   <= WR_DRESP;
                     end
                  end
                  WR_DRESP: begin
                     if (BUSY_BYTES == 0) begin
                        state_q <= WAIT_CMD;
                     end else begin
                        tx_next_q <= 8'h00;
                        cnt_q     <= BUSY_LAST;
                        state_q   <= WR_BUSY;
                     end
                  end
                  WR_BUSY: begin
                     if (cnt_q != 10'd0) begin
                        tx_next_q <= 8'h00;
                        cnt_q     <= cnt_q - 10'd1;
                     end else begin
                        state_q <= WAIT_CMD;
                     end
                  end
                  default: state_q <= WAIT_CMD;
               endcase
            end
         end
      end
   end

   assign bus.MISO        = tx_shift_q[7];
   assign bus.MEM_BLK     = blk_q;
   assign bus.MEM_IDX     = idx_q;
   assign bus.MEM_RD_STB  = rd_stb_q;
   assign bus.MEM_WR_STB  = wr_stb_q;
   assign bus.MEM_WR_DATA = wr_data_q;
   assign bus.IDLE_FLAG   = idle_q;
endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_spi_responder
// Purpose  : Self-checking bench: SPI host, byte memory model, scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi_responder;
   localparam int NCR     = 1;
   localparam int RETRIES = 2;
   localparam int GAP     = 2;
   localparam int BUSY    = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sd_spi_responder_if bus();

   sd_spi_responder #(
      .NCR_BYTES   (NCR),
      .INIT_RETRIES(RETRIES),
      .READ_GAP    (GAP),
      .BUSY_BYTES  (BUSY)
   ) dut (
      .CLOCK50(clk),
      .RESET  (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [16:0] wr_q[$];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [7:0]  mem_rd = 8'h00;
   logic        rd_prev = 1'b0;
   logic        wr_prev = 1'b0;

   assign bus.MEM_RD_DATA = mem_rd;

   // Memory model: block byte n holds n[7:0].
   always @(posedge clk) if (bus.MEM_RD_STB) mem_rd <= bus.MEM_IDX[7:0];

   always @(negedge clk) begin
      if (bus.MEM_RD_STB) begin
         checks++;
         if (rd_prev || bus.MEM_IDX != 9'(rd_cnt) || bus.MEM_BLK != 32'd5) begin
            errors++;
            $display("FAIL rd_stb: idx %0d blk %0d held %0b, want idx %0d blk 5 one-cycle",
                     bus.MEM_IDX, bus.MEM_BLK, rd_prev, rd_cnt);
         end
         rd_cnt++;
      end
      if (bus.MEM_WR_STB) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_stb: unexpected strobe idx %0d data %02h, want none",
                     bus.MEM_IDX, bus.MEM_WR_DATA);
         end else begin
            logic [16:0] e;
            e = wr_q.pop_front();
            if (wr_prev || {bus.MEM_IDX, bus.MEM_WR_DATA} !== e) begin
               errors++;
               $display("FAIL wr_stb: idx %0d data %02h held %0b, want idx %0d data %02h",
                        bus.MEM_IDX, bus.MEM_WR_DATA, wr_prev, e[16:8], e[7:0]);
            end
         end
         wr_cnt++;
      end
      rd_prev = bus.MEM_RD_STB;
      wr_prev = bus.MEM_WR_STB;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [5:0]  cmd;
      logic [31:0] arg;
      int          nresp;
      logic [39:0] resp;
      logic        idle_after;
   } vec_t;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         bus.MOSI = tx[i];
         tick(4);
         rx[i] = bus.MISO;
         bus.SCLK = 1'b1;
         tick(4);
         bus.SCLK = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input string nm);
      logic [7:0] rx, e;
      spi_byte(tx, rx);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got %02h, no expected byte queued", nm, rx);
      end else begin
         e = exp_q.pop_front();
         if (rx !== e) begin
            errors++;
            $display("FAIL %s: got %02h want %02h", nm, rx, e);
         end
      end
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg, input int nresp,
                          input logic [39:0] resp, input string nm);
      logic [7:0] fr[6];
      fr[0] = {2'b01, cmd};
      fr[1] = arg[31:24];
      fr[2] = arg[23:16];
      fr[3] = arg[15:8];
      fr[4] = arg[7:0];
      fr[5] = (cmd == 6'd0) ? 8'h95 : ((cmd == 6'd8) ? 8'h87 : 8'h01);
      for (int i = 0; i < 6 + NCR; i++) exp_q.push_back(8'hFF);
      for (int j = 0; j < nresp; j++) exp_q.push_back(resp[39-8*j -: 8]);
      for (int i = 0; i < 6; i++) xfer(fr[i], nm);
      for (int i = 0; i < NCR + nresp; i++) xfer(8'hFF, nm);
   endtask

   initial begin
      vec_t tbl[12];
      tbl[0]  = '{6'd0,  32'h0,      1, {8'h01, 32'h0},                   1'b1};
      tbl[1]  = '{6'd8,  32'h000001AA, 5, {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA}, 1'b1};
      tbl[2]  = '{6'd17, 32'd5,      1, {8'h05, 32'h0},                   1'b1};
      tbl[3]  = '{6'd55, 32'h0,      1, {8'h01, 32'h0},                   1'b1};
      tbl[4]  = '{6'd41, 32'h40000000, 1, {8'h01, 32'h0},                 1'b1};
      tbl[5]  = '{6'd55, 32'h0,      1, {8'h01, 32'h0},                   1'b1};
      tbl[6]  = '{6'd41, 32'h40000000, 1, {8'h01, 32'h0},                 1'b1};
      tbl[7]  = '{6'd55, 32'h0,      1, {8'h01, 32'h0},                   1'b1};
      tbl[8]  = '{6'd41, 32'h40000000, 1, {8'h00, 32'h0},                 1'b0};
      tbl[9]  = '{6'd58, 32'h0,      5, {8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00}, 1'b0};
      tbl[10] = '{6'd41, 32'h0,      1, {8'h04, 32'h0},                   1'b0};
      tbl[11] = '{6'd13, 32'h0,      1, {8'h04, 32'h0},                   1'b0};

      bus.SCLK = 1'b0;
      bus.MOSI = 1'b1;
      bus.CS   = 1'b1;
      rst_n    = 1'b0;
      tick(5);
      check("rst_miso",    64'(bus.MISO),        64'd1);
      check("rst_idle",    64'(bus.IDLE_FLAG),   64'd1);
      check("rst_rd_stb",  64'(bus.MEM_RD_STB),  64'd0);
      check("rst_wr_stb",  64'(bus.MEM_WR_STB),  64'd0);
      check("rst_blk",     64'(bus.MEM_BLK),     64'd0);
      check("rst_idx",     64'(bus.MEM_IDX),     64'd0);
      check("rst_wr_data", 64'(bus.MEM_WR_DATA), 64'd0);
      rst_n = 1'b1;
      tick(3);
      exp_q.push_back(8'hFF);
      xfer(8'h40, "cs_high_miso");

      bus.CS = 1'b0;
      tick(4);
      for (int k = 0; k < 12; k++) begin
         run_cmd(tbl[k].cmd, tbl[k].arg, tbl[k].nresp, tbl[k].resp, $sformatf("vec%0d", k));
         check($sformatf("vec%0d_idle", k), 64'(bus.IDLE_FLAG), 64'(tbl[k].idle_after));
      end

      // Single-block read of block 5.
      run_cmd(6'd17, 32'd5, 1, {8'h00, 32'h0}, "cmd17_r1");
      for (int i = 0; i < GAP; i++) exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int n = 0; n < 512; n++) exp_q.push_back(8'(n));
      repeat (3) exp_q.push_back(8'hFF);
      for (int i = 0; i < GAP + 1 + 512 + 3; i++) xfer(8'hFF, "cmd17_stream");
      check("rd_count", 64'(rd_cnt), 64'd512);
      check("rd_blk",   64'(bus.MEM_BLK), 64'd5);

      // Single-block write of block 7.
      run_cmd(6'd24, 32'd7, 1, {8'h00, 32'h0}, "cmd24_r1");
      check("wr_blk", 64'(bus.MEM_BLK), 64'd7);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      xfer(8'hFF, "cmd24_pre");
      xfer(8'hFE, "cmd24_token");
      for (int n = 0; n < 512; n++) begin
         exp_q.push_back(8'hFF);
         wr_q.push_back({9'(n), 8'(n)});
         xfer(8'(n), "cmd24_data");
      end
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h05);
      for (int i = 0; i < BUSY; i++) exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      for (int i = 0; i < 2 + 1 + BUSY + 1; i++) xfer(8'hFF, "cmd24_tail");
      check("wr_count", 64'(wr_cnt), 64'd512);
      check("wr_q_empty", 64'(wr_q.size()), 64'd0);

      // Write aborted by CS after 100 data bytes.
      run_cmd(6'd24, 32'd9, 1, {8'h00, 32'h0}, "abort_r1");
      exp_q.push_back(8'hFF);
      xfer(8'hFE, "abort_token");
      for (int n = 0; n < 100; n++) begin
         exp_q.push_back(8'hFF);
         wr_q.push_back({9'(n), 8'(n + 3)});
         xfer(8'(n + 3), "abort_data");
      end
      tick(2);
      bus.CS = 1'b1;
      tick(10);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      xfer(8'h55, "abort_cs_high");
      xfer(8'hAA, "abort_cs_high");
      check("abort_wr_count", 64'(wr_cnt), 64'd612);
      check("abort_q_empty",  64'(wr_q.size()), 64'd0);
      check("abort_idle",     64'(bus.IDLE_FLAG), 64'd0);
      bus.CS = 1'b0;
      tick(4);
      run_cmd(6'd0, 32'h0, 1, {8'h01, 32'h0}, "post_abort_cmd0");
      check("post_abort_idle", 64'(bus.IDLE_FLAG), 64'd1);
      check("post_abort_rd",   64'(rd_cnt), 64'd512);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
